// File: rtl/fg_event_monitor.sv
// Observer for the registered f/g stage: counts f rising edges, tracks the longest g high run
// and checks that every f rise is followed by a g rise within WINDOW clocks.
module fg_event_monitor #(
    parameter int CNT_W  = 8,
    parameter int WINDOW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             f_in,
    input  logic             g_in,
    output logic [CNT_W-1:0] f_rise_cnt,
    output logic [CNT_W-1:0] g_max_run,
    output logic             match,
    output logic             miss,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HIT,
        MISS
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_n;
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] run_inc;
    logic             f_q;
    logic             g_q;
    logic             f_rise;
    logic             g_rise;

    assign f_rise  = f_in & ~f_q;
    assign g_rise  = g_in & ~g_q;
    assign run_inc = (run == CNT_MAX) ? CNT_MAX : run + CNT_W'(1);

    // Statistics; a clear takes priority over any increment on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_q        <= 1'b0;
            g_q        <= 1'b0;
            f_rise_cnt <= '0;
            g_max_run  <= '0;
            run        <= '0;
        end else begin
            f_q <= f_in;
            g_q <= g_in;
            if (clr) begin
                f_rise_cnt <= '0;
                g_max_run  <= '0;
                run        <= '0;
            end else begin
                if (f_rise && (f_rise_cnt != CNT_MAX))
                    f_rise_cnt <= f_rise_cnt + CNT_W'(1);
                run <= g_in ? run_inc : '0;
                if (g_in && (run_inc > g_max_run))
                    g_max_run <= run_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_n;
            timer <= timer_n;
        end
    end

    // While ARMED, extra f rises are ignored here so the window is never extended.
    always_comb begin
        state_n = state;
        timer_n = timer;
        case (state)
            IDLE: begin
                if (f_rise) begin
                    state_n = ARMED;
                    timer_n = '0;
                end
            end
            ARMED: begin
                if (g_rise)
                    state_n = HIT;
                else if (timer == WIN_LAST)
                    state_n = MISS;
                else
                    timer_n = timer + CNT_W'(1);
            end
            HIT, MISS: begin
                if (f_rise) begin
                    state_n = ARMED;
                    timer_n = '0;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign match = (state == HIT);
    assign miss  = (state == MISS);
    assign busy  = (state == ARMED);

endmodule

// File: tb/tb_fg_event_monitor.sv
// Self-checking bench for fg_event_monitor: an edge-indexed reference model compared every cycle,
// plus directed sequences with hand-computed literal expectations.
module tb_fg_event_monitor;

    localparam int CNT_W  = 8;
    localparam int WINDOW = 4;
    localparam int MAXV   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             clr = 1'b0;
    logic             fIn = 1'b0;
    logic             gIn = 1'b0;
    logic [CNT_W-1:0] f_rise_cnt;
    logic [CNT_W-1:0] g_max_run;
    logic             match;
    logic             miss;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    fg_event_monitor #(.CNT_W(CNT_W), .WINDOW(WINDOW)) dut (
        .clk        (clk),
        .rst        (rst),
        .clr        (clr),
        .f_in       (fIn),
        .g_in       (gIn),
        .f_rise_cnt (f_rise_cnt),
        .g_max_run  (g_max_run),
        .match      (match),
        .miss       (miss),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: windows are tracked by the edge index at which they were armed.
    bit modelValid = 1'b0;
    int mEdge, mArmEdge, mCnt, mRun, mMaxRun;
    bit mPrevF, mPrevG, mMatch, mMiss, mBusy;

    task automatic modelReset();
        modelValid = 1'b1;
        mEdge      = 0;
        mArmEdge   = -1;
        mCnt       = 0;
        mRun       = 0;
        mMaxRun    = 0;
        mPrevF     = 1'b0;
        mPrevG     = 1'b0;
        mMatch     = 1'b0;
        mMiss      = 1'b0;
        mBusy      = 1'b0;
    endtask

    always @(posedge rst) modelReset();

    always @(posedge clk) begin
        if (rst) begin
            modelReset();
        end else if (modelValid) begin
            bit fr, gr;
            fr     = fIn && !mPrevF;
            gr     = gIn && !mPrevG;
            mMatch = 1'b0;
            mMiss  = 1'b0;
            if (mArmEdge >= 0) begin
                if (gr) begin
                    mMatch   = 1'b1;
                    mArmEdge = -1;
                end else if (mEdge - mArmEdge == WINDOW) begin
                    mMiss    = 1'b1;
                    mArmEdge = -1;
                end
            end else if (fr) begin
                mArmEdge = mEdge;
            end
            mBusy = (mArmEdge >= 0);
            if (clr) begin
                mCnt    = 0;
                mRun    = 0;
                mMaxRun = 0;
            end else begin
                if (fr && mCnt < MAXV) mCnt++;
                mRun = gIn ? mRun + 1 : 0;
                if (mRun > mMaxRun) mMaxRun = mRun;
            end
            mPrevF = fIn;
            mPrevG = gIn;
            mEdge++;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && modelValid) begin
            checkOutput("cmp_f_rise_cnt", int'(f_rise_cnt), mCnt);
            checkOutput("cmp_g_max_run", int'(g_max_run), (mMaxRun > MAXV) ? MAXV : mMaxRun);
            checkOutput("cmp_match", int'(match), int'(mMatch));
            checkOutput("cmp_miss", int'(miss), int'(mMiss));
            checkOutput("cmp_busy", int'(busy), int'(mBusy));
        end
    end

    task automatic applyStimulus(input logic f, input logic g, input logic c);
        @(negedge clk);
        fIn = f;
        gIn = g;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    int busyCnt, matchCnt, missCnt, matchAt, missAt;

    // Bit i of fv/gv is driven for edge k+i; outcomes are recorded by that index.
    task automatic runSeq(input logic [31:0] fv, input logic [31:0] gv, input int n);
        busyCnt  = 0;
        matchCnt = 0;
        missCnt  = 0;
        matchAt  = -1;
        missAt   = -1;
        for (int i = 0; i < n; i++) begin
            applyStimulus(fv[i], gv[i], 1'b0);
            if (busy) busyCnt++;
            if (match) begin
                matchCnt++;
                if (matchAt < 0) matchAt = i;
            end
            if (miss) begin
                missCnt++;
                if (missAt < 0) missAt = i;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cntBefore;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_cnt", int'(f_rise_cnt), 0);
        checkOutput("reset_gmax", int'(g_max_run), 0);
        checkOutput("reset_flags", int'({match, miss, busy}), 0);

        // f pulse, g rises two edges later
        runSeq(32'h1, 32'h4, 6);
        checkOutput("t1_cnt", int'(f_rise_cnt), 1);
        checkOutput("t1_busy", busyCnt, 2);
        checkOutput("t1_match", matchCnt, 1);
        checkOutput("t1_match_at", matchAt, 2);
        checkOutput("t1_miss", missCnt, 0);

        // no g at all: window expires
        runSeq(32'h1, 32'h0, 7);
        checkOutput("t2_busy", busyCnt, 4);
        checkOutput("t2_miss", missCnt, 1);
        checkOutput("t2_miss_at", missAt, 4);
        checkOutput("t2_match", matchCnt, 0);

        // g rise on the last window edge still matches
        runSeq(32'h1, 32'h10, 7);
        checkOutput("t7_match_at", matchAt, 4);
        checkOutput("t7_miss", missCnt, 0);

        // f and g rise together; g held 10 cycles
        runSeq(32'h1, 32'h3FF, 12);
        checkOutput("t3_match", matchCnt, 0);
        checkOutput("t3_miss_at", missAt, 4);
        checkOutput("t3_gmax", int'(g_max_run), 10);

        // saturation, then clear beating a same-edge rise
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0);
        end
        checkOutput("t4_sat", int'(f_rise_cnt), 255);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("t4_clr_cnt", int'(f_rise_cnt), 0);
        checkOutput("t4_clr_gmax", int'(g_max_run), 0);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);

        // second f rise while armed
        cntBefore = int'(f_rise_cnt);
        runSeq(32'h5, 32'h0, 8);
        checkOutput("t5_cnt", int'(f_rise_cnt), cntBefore + 2);
        checkOutput("t5_miss", missCnt, 1);
        checkOutput("t5_miss_at", missAt, 4);
        checkOutput("t5_busy", busyCnt, 4);

        // asynchronous reset while armed
        runSeq(32'h0, 32'h7, 4);
        checkOutput("t6_gmax_pre", int'(g_max_run), 3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t6_busy_pre", int'(busy), 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("t6_busy_rst", int'(busy), 0);
        checkOutput("t6_cnt_rst", int'(f_rise_cnt), 0);
        checkOutput("t6_gmax_rst", int'(g_max_run), 0);
        @(negedge clk);
        rst = 1'b0;
        runSeq(32'h0, 32'h0, 6);
        checkOutput("t6_match_after", matchCnt, 0);
        checkOutput("t6_miss_after", missCnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
